// File: rtl/ins_line_cache.sv
// Direct-mapped instruction line cache with a two-state refill FSM.
// Hits return the stored word in the same cycle; a miss stalls the PC while the line refills one word per cycle.
module ins_line_cache #(
    parameter int dataW        = 32,
    parameter int RAMAddrSize  = 32,
    parameter int Lines        = 8,
    parameter int WordsPerLine = 4,
    parameter int MissCntW     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [dataW-1:0]       ProgAddr,
    input  logic                   Flush,
    input  logic [dataW-1:0]       RAMOut,
    output logic                   InsCacheStall,
    output logic [RAMAddrSize-1:0] InsCacheReadAddr,
    output logic [dataW-1:0]       OutputIns,
    output logic [MissCntW-1:0]    MissCount
);

    localparam int OffW = $clog2(WordsPerLine);
    localparam int IdxW = $clog2(Lines);
    localparam int TagW = RAMAddrSize - 2 - OffW - IdxW;
    localparam logic [dataW-1:0] NOP = dataW'(32'h0000_0013);
    localparam logic [OffW-1:0] LAST_WORD = OffW'(WordsPerLine - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                 r_state;
    logic [OffW-1:0]        r_cnt;
    logic [Lines-1:0]       r_valid;
    logic [TagW-1:0]        r_tag  [Lines];
    logic [dataW-1:0]       r_data [Lines*WordsPerLine];
    logic [RAMAddrSize-1:0] r_base;
    logic [MissCntW-1:0]    r_miss;

    logic [RAMAddrSize-1:0] w_addr;
    logic [OffW-1:0]        w_off;
    logic [IdxW-1:0]        w_idx;
    logic [TagW-1:0]        w_tag;
    logic [RAMAddrSize-1:0] w_line_base;
    logic [IdxW-1:0]        w_base_idx;
    logic [TagW-1:0]        w_base_tag;
    logic                   w_hit;
    logic                   w_stall;

    assign w_addr      = ProgAddr[RAMAddrSize-1:0];
    assign w_off       = w_addr[2 +: OffW];
    assign w_idx       = w_addr[2+OffW +: IdxW];
    assign w_tag       = w_addr[RAMAddrSize-1 -: TagW];
    assign w_line_base = {w_addr[RAMAddrSize-1:2+OffW], {(2+OffW){1'b0}}};
    assign w_base_idx  = r_base[2+OffW +: IdxW];
    assign w_base_tag  = r_base[RAMAddrSize-1 -: TagW];

    assign w_hit   = (r_state == IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_stall = reset || !w_hit;

    assign InsCacheStall    = w_stall;
    assign OutputIns        = w_stall ? NOP : r_data[{w_idx, w_off}];
    assign InsCacheReadAddr = (r_state == REFILL)
                            ? {r_base[RAMAddrSize-1:2+OffW], r_cnt, 2'b00}
                            : w_line_base;
    assign MissCount        = r_miss;

    // Flush outranks everything: it aborts a refill and suppresses a miss in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= '0;
            r_base  <= '0;
            r_miss  <= '0;
        end else if (Flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_hit) begin
                        r_base  <= w_line_base;
                        r_cnt   <= '0;
                        r_state <= REFILL;
                        if (r_miss != '1) r_miss <= r_miss + MissCntW'(1);
                    end
                end
                REFILL: begin
                    r_cnt <= r_cnt + OffW'(1);
                    if (r_cnt == '0) r_valid[w_base_idx] <= 1'b0;
                    if (r_cnt == LAST_WORD) begin
                        r_valid[w_base_idx] <= 1'b1;
                        r_state             <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: data and tag arrays carry no reset; the valid bits alone decide whether their contents are used.
    always_ff @(posedge clock) begin
        if (r_state == REFILL) begin
            r_data[{w_base_idx, r_cnt}] <= RAMOut;
            if (r_cnt == LAST_WORD) r_tag[w_base_idx] <= w_base_tag;
        end
    end

endmodule

// File: tb/tb_ins_line_cache.sv
// Directed bench for ins_line_cache: RAM word at byte address a reads as 0xA000_0000 + a.
// A second narrow-counter instance exercises miss-counter saturation in a few hundred cycles.
module tb_ins_line_cache;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ProgAddr;
    logic        Flush;
    logic [31:0] RAMOut;
    logic        InsCacheStall;
    logic [31:0] InsCacheReadAddr;
    logic [31:0] OutputIns;
    logic [15:0] MissCount;

    logic [31:0] s_prog;
    logic        s_flush;
    logic [31:0] s_ramout;
    logic        s_stall;
    logic [31:0] s_raddr;
    logic [31:0] s_out;
    logic [3:0]  s_miss;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clock = ~clock;

    assign RAMOut   = 32'hA000_0000 + InsCacheReadAddr;
    assign s_ramout = 32'hA000_0000 + s_raddr;

    ins_line_cache dut (
        .clock            (clock),
        .reset            (reset),
        .ProgAddr         (ProgAddr),
        .Flush            (Flush),
        .RAMOut           (RAMOut),
        .InsCacheStall    (InsCacheStall),
        .InsCacheReadAddr (InsCacheReadAddr),
        .OutputIns        (OutputIns),
        .MissCount        (MissCount)
    );

    ins_line_cache #(.MissCntW(4)) sat_dut (
        .clock            (clock),
        .reset            (reset),
        .ProgAddr         (s_prog),
        .Flush            (s_flush),
        .RAMOut           (s_ramout),
        .InsCacheStall    (s_stall),
        .InsCacheReadAddr (s_raddr),
        .OutputIns        (s_out),
        .MissCount        (s_miss)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full miss on addr: one IDLE miss cycle, four refill cycles with a junk ProgAddr, then a hit.
    task automatic miss_refill(input logic [31:0] addr, input logic [15:0] exp_cnt);
        logic [31:0] base;
        base     = addr & 32'hFFFF_FFF0;
        ProgAddr = addr;
        #1;
        check("miss_stall", 32'(InsCacheStall), 32'd1);
        check("miss_idle_addr", InsCacheReadAddr, base);
        check("miss_nop", OutputIns, NOP);
        for (int k = 0; k < 4; k++) begin
            tick();
            ProgAddr = addr ^ 32'h0000_0200;
            #1;
            check("refill_stall", 32'(InsCacheStall), 32'd1);
            check("refill_addr", InsCacheReadAddr, base + 32'(4 * k));
            check("refill_nop", OutputIns, NOP);
        end
        tick();
        ProgAddr = addr;
        #1;
        check("after_refill_stall", 32'(InsCacheStall), 32'd0);
        check("after_refill_data", OutputIns, 32'hA000_0000 + addr);
        check("after_refill_misses", 32'(MissCount), 32'(exp_cnt));
    endtask

    task automatic expect_hit(input logic [31:0] addr, input logic [15:0] exp_cnt);
        ProgAddr = addr;
        #1;
        check("hit_stall", 32'(InsCacheStall), 32'd0);
        check("hit_data", OutputIns, 32'hA000_0000 + addr);
        check("hit_misses", 32'(MissCount), 32'(exp_cnt));
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        ProgAddr = 32'h0;
        Flush    = 1'b0;
        s_prog   = 32'h0000_0100;
        s_flush  = 1'b0;
        tick();
        tick();
        check("reset_stall", 32'(InsCacheStall), 32'd1);
        check("reset_nop", OutputIns, NOP);
        check("reset_misses", 32'(MissCount), 32'd0);

        // Cold miss at 0x0, then hits on the rest of the line
        reset = 1'b0;
        miss_refill(32'h0000_0000, 16'd1);
        tick();
        expect_hit(32'h0000_0004, 16'd1);
        expect_hit(32'h0000_0008, 16'd1);
        expect_hit(32'h0000_000C, 16'd1);

        // Last index, last word
        miss_refill(32'h0000_007C, 16'd2);
        tick();

        // Conflict misses on index 0; line 7 must survive
        miss_refill(32'h0000_0080, 16'd3);
        tick();
        miss_refill(32'h0000_0000, 16'd4);
        tick();
        expect_hit(32'h0000_007C, 16'd4);

        // Flush during the second refill cycle aborts the fill
        ProgAddr = 32'h0000_0040;
        #1;
        check("abort_miss_stall", 32'(InsCacheStall), 32'd1);
        tick();
        tick();
        Flush = 1'b1;
        #1;
        check("abort_refill_addr", InsCacheReadAddr, 32'h0000_0044);
        tick();
        Flush = 1'b0;
        #1;
        check("abort_idle_stall", 32'(InsCacheStall), 32'd1);
        check("abort_idle_addr", InsCacheReadAddr, 32'h0000_0040);
        check("abort_misses", 32'(MissCount), 32'd5);
        miss_refill(32'h0000_0040, 16'd6);
        tick();

        // Flush together with an IDLE miss: no refill entry, count unchanged
        ProgAddr = 32'h0000_0020;
        Flush    = 1'b1;
        #1;
        check("flush_miss_stall", 32'(InsCacheStall), 32'd1);
        tick();
        Flush    = 1'b0;
        ProgAddr = 32'h0000_0040;
        #1;
        check("flushed_line_miss", 32'(InsCacheStall), 32'd1);
        check("flush_miss_count", 32'(MissCount), 32'd6);
        check("flush_no_refill_addr", InsCacheReadAddr, 32'h0000_0040);
        miss_refill(32'h0000_0020, 16'd7);
        tick();

        // Reset in the third refill cycle
        ProgAddr = 32'h0000_0060;
        #1;
        tick();
        tick();
        tick();
        check("third_refill_addr", InsCacheReadAddr, 32'h0000_0068);
        reset = 1'b1;
        #1;
        check("midreset_stall", 32'(InsCacheStall), 32'd1);
        check("midreset_nop", OutputIns, NOP);
        check("midreset_misses", 32'(MissCount), 32'd0);
        reset = 1'b0;
        #1;
        check("postreset_stall", 32'(InsCacheStall), 32'd1);
        check("postreset_addr", InsCacheReadAddr, 32'h0000_0060);
        miss_refill(32'h0000_0060, 16'd1);
        tick();

        // Saturation on the 4-bit counter instance, alternating tags on one index
        check("sat_start", 32'(s_miss), 32'd1);
        for (int i = 0; i < 20; i++) begin
            int e;
            s_prog = (i % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100;
            repeat (5) tick();
            #1;
            e = (i + 2 > 15) ? 15 : i + 2;
            check("sat_stall", 32'(s_stall), 32'd0);
            check("sat_data", s_out, 32'hA000_0000 + s_prog);
            check("sat_count", 32'(s_miss), 32'(e));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
